// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and flag bit positions.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD = 5'd1,
    OP_SUB = 5'd2,
    OP_MUL = 5'd3,
    OP_MOV = 5'd4,
    OP_SLL = 5'd5,
    OP_SRL = 5'd6,
    OP_SRA = 5'd7,
    OP_ROR = 5'd8,
    OP_AND = 5'd9,
    OP_OR  = 5'd10,
    OP_XOR = 5'd11,
    OP_NOT = 5'd12
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: next result and N/Z/C/V flags from opcode and operands.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       i_alu_ctrl,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  logic [4:0]       w_shamt;
  logic [WIDTH:0]   w_add;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_mul;
  logic [WIDTH:0]   w_sll_ext;
  logic [WIDTH:0]   w_srl_ext;
  logic [WIDTH:0]   w_sra_ext;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  assign w_shamt = i_src_b[4:0];
  assign w_add   = {1'b0, i_src_a} + {1'b0, i_src_b};
  assign w_sub   = i_src_a - i_src_b;
  assign w_mul   = i_src_a * i_src_b;

  // One guard bit beyond the shifted edge captures the last bit shifted out;
  // a zero shift leaves the guard bit at 0, which gives C=0 for free.
  assign w_sll_ext = {1'b0, i_src_a} << w_shamt;
  assign w_srl_ext = {i_src_a, 1'b0} >> w_shamt;
  assign w_sra_ext = $signed({i_src_a, 1'b0}) >>> w_shamt;
  assign w_ror     = (i_src_a >> w_shamt) | (i_src_a << (WIDTH - int'(w_shamt)));

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_alu_ctrl)
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (i_src_a[WIDTH-1] == i_src_b[WIDTH-1]) &&
                (w_add[WIDTH-1] != i_src_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub;
        w_c   = (i_src_a >= i_src_b);
        w_v   = (i_src_a[WIDTH-1] != i_src_b[WIDTH-1]) &&
                (w_sub[WIDTH-1] != i_src_a[WIDTH-1]);
      end
      OP_MUL: w_res = w_mul;
      OP_MOV: w_res = i_src_a;
      OP_SLL: begin
        w_res = w_sll_ext[WIDTH-1:0];
        w_c   = w_sll_ext[WIDTH];
      end
      OP_SRL: begin
        w_res = w_srl_ext[WIDTH:1];
        w_c   = w_srl_ext[0];
      end
      OP_SRA: begin
        w_res = w_sra_ext[WIDTH:1];
        w_c   = w_sra_ext[0];
      end
      OP_ROR: begin
        w_res = w_ror;
        w_c   = (w_shamt != 5'd0) && w_ror[WIDTH-1];
      end
      OP_AND: w_res = i_src_a & i_src_b;
      OP_OR:  w_res = i_src_a | i_src_b;
      OP_XOR: w_res = i_src_a ^ i_src_b;
      OP_NOT: w_res = ~i_src_a;
      default: w_res = '0;
    endcase
  end

  assign o_result         = w_res;
  assign o_flags[FLAG_N]  = w_res[WIDTH-1];
  assign o_flags[FLAG_Z]  = (w_res == '0);
  assign o_flags[FLAG_C]  = w_c;
  assign o_flags[FLAG_V]  = w_v;

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency wrapper around alu_comb with synchronous reset.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       alu_ctrl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags
);

  logic [WIDTH-1:0] w_next_result;
  logic [3:0]       w_next_flags;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .i_alu_ctrl (alu_ctrl),
    .i_src_a    (srcA),
    .i_src_b    (srcB),
    .o_result   (w_next_result),
    .o_flags    (w_next_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_flags  <= 4'b0000;
    end else begin
      r_result <= w_next_result;
      r_flags  <= w_next_flags;
    end
  end

  assign result    = r_result;
  assign alu_flags = r_flags;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes hand-computed expectations, monitor pops one per clock.
module tb_alu;

  localparam int WIDTH = 32;

  typedef struct {
    logic              rst;
    logic [4:0]        ctrl;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH-1:0]  exp_r;
    logic [3:0]        exp_f;
    string             name;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [4:0]       alu_ctrl;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [WIDTH-1:0] result;
  logic [3:0]       alu_flags;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_ctrl  (alu_ctrl),
    .srcA      (srcA),
    .srcB      (srcB),
    .result    (result),
    .alu_flags (alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic r, input logic [4:0] c, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] er,
                         input logic [3:0] ef, input string nm);
    vec_t v;
    v.rst = r; v.ctrl = c; v.a = a; v.b = b; v.exp_r = er; v.exp_f = ef; v.name = nm;
    vecs.push_back(v);
  endtask

  // Monitor: one output per clock, compared against the oldest expectation.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_popped++;
        n_checks++;
        if (result !== e.exp_r || alu_flags !== e.exp_f) begin
          n_errors++;
          $display("FAIL %s: got result=%h flags=%b, expected result=%h flags=%b",
                   e.name, result, alu_flags, e.exp_r, e.exp_f);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, pushed=%0d popped=%0d", n_pushed, n_popped);
    $fatal(1, "timeout");
  end

  // flags = {N,Z,C,V}
  initial begin
    rst = 1'b1; alu_ctrl = 5'd0; srcA = '0; srcB = '0;

    add_vec(1, 5'd1,  32'h1234_5678, 32'h1, 32'h0, 4'b0000, "reset0");
    add_vec(1, 5'd12, 32'h0,         32'h0, 32'h0, 4'b0000, "reset1");
    add_vec(0, 5'd1,  32'h1,         32'h5, 32'h6, 4'b0000, "add_1_5");
    add_vec(0, 5'd1,  32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110, "add_carry_zero");
    add_vec(0, 5'd2,  32'h2,         32'h1, 32'h1, 4'b0010, "sub_2_1");
    add_vec(0, 5'd2,  32'h1,         32'h2, 32'hFFFF_FFFF, 4'b1000, "sub_1_2");
    add_vec(0, 5'd2,  32'h5,         32'h5, 32'h0, 4'b0110, "sub_equal");
    add_vec(0, 5'd2,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0011, "sub_ovf");
    add_vec(0, 5'd1,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE, 4'b0010, "add_no_ovf");
    add_vec(0, 5'd1,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001, "add_ovf");
    add_vec(0, 5'd3,  32'h2,         32'h8, 32'h10, 4'b0000, "mul_2_8");
    add_vec(0, 5'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 4'b0000, "mul_wrap");
    add_vec(0, 5'd4,  32'hF,         'x,    32'hF, 4'b0000, "mov_x");
    add_vec(0, 5'd9,  32'h1,         32'h1, 32'h1, 4'b0000, "and");
    add_vec(0, 5'd10, 32'h0,         32'h1, 32'h1, 4'b0000, "or");
    add_vec(0, 5'd11, 32'h0,         32'h1, 32'h1, 4'b0000, "xor");
    add_vec(0, 5'd12, 32'h0,         'x,    32'hFFFF_FFFF, 4'b1000, "not");
    add_vec(0, 5'd20, 32'h5,         32'h7, 32'h0, 4'b0100, "undef20");
    add_vec(0, 5'd0,  32'h5,         32'h7, 32'h0, 4'b0100, "undef0");
    add_vec(0, 5'd13, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0100, "undef13");
    add_vec(0, 5'd5,  32'h8000_0001, 32'h1, 32'h2, 4'b0010, "sll_1");
    add_vec(0, 5'd5,  32'h5,         32'h0, 32'h5, 4'b0000, "sll_0");
    add_vec(0, 5'd5,  32'h5,         32'h20, 32'h5, 4'b0000, "sll_b32");
    add_vec(0, 5'd7,  32'h8000_0000, 32'h4, 32'hF800_0000, 4'b1000, "sra_4");
    add_vec(0, 5'd6,  32'h8000_0000, 32'h1F, 32'h1, 4'b0000, "srl_31");
    add_vec(0, 5'd6,  32'h3,         32'h1, 32'h1, 4'b0010, "srl_c");
    add_vec(0, 5'd8,  32'h1,         32'h1, 32'h8000_0000, 4'b1010, "ror_1");
    add_vec(0, 5'd8,  32'h1234_5678, 32'h8, 32'h7812_3456, 4'b0000, "ror_8");
    add_vec(0, 5'd8,  32'h8000_0001, 32'h0, 32'h8000_0001, 4'b1000, "ror_0");
    add_vec(0, 5'd1,  32'h3,         32'h4, 32'h7, 4'b0000, "add_pre_rst");
    add_vec(1, 5'd1,  32'hA,         32'h14, 32'h0, 4'b0000, "mid_rst");
    add_vec(0, 5'd1,  32'h1,         32'h1, 32'h2, 4'b0000, "add_post_rst");
    add_vec(0, 5'd2,  32'h0,         32'h1, 32'hFFFF_FFFF, 4'b1000, "sub_back2back");

    foreach (vecs[i]) begin
      @(negedge clk);
      rst      = vecs[i].rst;
      alu_ctrl = vecs[i].ctrl;
      srcA     = vecs[i].a;
      srcB     = vecs[i].b;
      sb.push_back(vecs[i]);
      n_pushed++;
    end
    @(negedge clk);
    rst = 1'b0; alu_ctrl = 5'd0;
    repeat (3) @(negedge clk);

    n_checks++;
    if (sb.size() != 0 || n_popped != n_pushed) begin
      n_errors++;
      $display("FAIL drain: popped=%0d left=%0d, expected popped=%0d left=0",
               n_popped, sb.size(), n_pushed);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 32, data path width of srcA, srcB and result.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 alu_ctrl  input  5  operation select, encoding per REQ-008.
REQ-005 srcA  input  WIDTH  first operand.
REQ-006 srcB  input  WIDTH  second operand.
REQ-007 Outputs SHALL be:
- result  output  WIDTH  registered operation result.
- alu_flags  output  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V.

Function
REQ-008 alu_ctrl encoding SHALL be:
- 1 ADD: A+B.
- 2 SUB: A-B.
- 3 MUL: low WIDTH bits of A*B, unsigned.
- 4 MOV: A.
- 5 SLL: A<<B[4:0].
- 6 SRL: A>>B[4:0], logical.
- 7 SRA: A>>>B[4:0], arithmetic.
- 8 ROR: A rotated right by B[4:0].
- 9 AND: A&B.
- 10 OR: A|B.
- 11 XOR: A^B.
- 12 NOT: ~A.
REQ-009 All other alu_ctrl values, including 0 and 13-31, SHALL produce result 0.
REQ-010 Latency SHALL be one cycle: inputs sampled at rising edge k appear on result/alu_flags after edge k; outputs are held until the next edge.
REQ-011 The unit SHALL accept a new operation every cycle; there is no handshake and no stall.
REQ-012 N SHALL equal result[WIDTH-1] and Z SHALL equal (result==0) for every operation, including undefined codes.
REQ-013 ADD flags:
- C = carry out of bit WIDTH-1.
- V = 1 when the operands have equal signs and the result sign differs.
REQ-014 SUB flags:
- C = 1 when A>=B unsigned (no borrow).
- V = 1 when the operand signs differ and the result sign differs from A.
REQ-015 Shift flags (SLL/SRL/SRA/ROR): C = last bit shifted out; C=0 when the shift amount is 0; V=0.
REQ-016 MUL, MOV, AND, OR, XOR, NOT and undefined codes SHALL force C=0 and V=0.
REQ-017 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.
REQ-018 X/Z on unused operands (e.g. srcB during MOV or NOT) SHALL NOT affect result or flags.

Reset
REQ-019 While rst=1 at a rising edge, result SHALL become 0 and alu_flags SHALL become 4'b0000, regardless of the other inputs.
REQ-020 The first cycle after rst deasserts SHALL compute normally from the inputs sampled at that edge.

Structure
REQ-021 A shared package alu_pkg SHALL hold the alu_ctrl opcode constants (or an enum) and the flag bit-index constants.
REQ-022 The combinational datapath SHALL be a single sub-module, alu_comb, producing next result and flags; alu registers its outputs.

Verification
REQ-023 ADD: A=1, B=5 -> result=6, flags=0000; A=0xFFFFFFFF, B=1 -> result=0, flags N0 Z1 C1 V0.
REQ-024 SUB and overflow:
- A=2, B=1 -> result=1, C=1.
- A=1, B=2 -> result=0xFFFFFFFF, N=1, C=0.
- A=0x7FFFFFFF, B=0xFFFFFFFF with ADD -> result=0x7FFFFFFE, V=0; A=0x7FFFFFFF, B=1 with ADD -> V=1.
REQ-025 MUL and MOV: A=2, B=8 MUL -> 16; A=15 MOV -> 15 for any B, including X.
REQ-026 Logic and NOT:
- AND 1,1 -> 1.
- OR 0,1 -> 1.
- XOR 0,1 -> 1.
- NOT 0 -> 0xFFFFFFFF, N=1.
- Undefined code 20 -> result 0, Z=1.
REQ-027 Shifts: SLL 0x80000001 by 1 -> 2, C=1; SRA 0x80000000 by 4 -> 0xF8000000; ROR 1 by 1 -> 0x80000000.
REQ-028 Reset mid-stream: assert rst for one edge between back-to-back ADDs -> outputs 0/0000 for that cycle, with a correct result on the next edge; confirm one-cycle latency throughout.
